systolic_stream_ctrl: RTL and testbench
=======================================

# systolic_stream_ctrl

Host-side initiator for the 3x3 systolic integer multiplier array. Accepts one A/B operand pair (nine elements each) over a valid/ready handshake and drives the array's five A lanes and five B lanes with the three skewed wavefronts, followed by zeros. It then captures the nine products from the array's five result taps at fixed offsets and presents the 3x3 result over a valid/ready handshake. The array itself contains no control or reset; this block supplies both.

## Interface
- `N`, 5, operand element width.
- `RES_W`, 2*N+4, result element width; must match the array's result taps.
- `CAP_LAT`, 5, edges from the wavefront-0 edge to the first capture edge.
- `clk` in 1, single clock; all logic is on its rising edge.
- `rst` in 1, synchronous, active-high reset.
- `in_valid` in 1, operand pair is valid.
- `in_ready` out 1, block can accept; high only in IDLE (combinational from state).
- `a_flat` in 9*N, A row-major: a11 at [N-1:0] … a33 at the MSBs.
- `b_flat` in 9*N, B row-major, same packing as `a_flat`.
- `lane_a` out 5*N, array A lanes 0..4; lane 0 at the LSBs.
- `lane_b` out 5*N, array B lanes 0..4.
- `res_tap` in 5*RES_W, array taps 0..4 = PE19, PE16, PE12, PE18, PE17 result outputs.
- `out_valid` out 1, `c_flat` holds a complete result.
- `out_ready` in 1, consumer accepts the result.
- `c_flat` out 9*RES_W, C row-major: c11 at the LSBs.

## Operation
- States: DRAIN, IDLE, FEED0, FEED1, FEED2, WAIT, CAP0, CAP1, CAP2, HOLD.
- Accept: `in_valid && in_ready` at edge E0.
  - E0 registers wavefront 0: A lanes = {a11,a12,a13,0,0}, B lanes = {b11,b21,b31,0,0}.
  - Operands are latched internally at E0, so the inputs may change afterwards.
- E0+1 registers wavefront 1: A = {0,a21,a22,a23,0}, B = {0,b12,b22,b32,0}.
- E0+2 registers wavefront 2: A = {0,0,a31,a32,a33}, B = {0,0,b13,b23,b33}.
- From E0+3 both lane buses are all-zero.
- Capture edges, with K = CAP_LAT:
  - E0+K: c11←tap0, c12←tap1, c13←tap2, c21←tap3, c31←tap4.
  - E0+K+1: c22←tap0, c23←tap1, c32←tap3.
  - E0+K+2: c33←tap0.
- `out_valid` is set at edge E0+K+2 (state HOLD).
- `c_flat` is stable while `out_valid` is high.
- HOLD→IDLE on the edge where `out_ready` is high; `out_valid` falls on that same edge.
- `in_valid` outside IDLE is ignored; no operands are latched.
- `out_ready` while `out_valid` is low is ignored.
- Arithmetic: none in this block. Results are captured unsigned at RES_W bits, with no truncation.

## Timing
- Reset values: `lane_a` = 0, `lane_b` = 0, `c_flat` = 0, `out_valid` = 0, `in_ready` = 0.
- On reset, state = DRAIN with drain counter = CAP_LAT+3.
- DRAIN lasts CAP_LAT+3 cycles with zero lanes, flushing stale partial sums left in the unreset array. It then moves to IDLE.
- `rst` mid-operation in any state behaves exactly like power-up reset: the operation is abandoned, no `out_valid` is produced, and DRAIN is re-entered.
- Accept-to-`out_valid` latency: CAP_LAT+2 edges (7 by default).
- Minimum spacing between accepts: CAP_LAT+4 cycles when `out_ready` is tied high.
- `out_ready` held high during HOLD entry: `out_valid` is high for exactly one cycle.

## Configuration
- `SYSTOLIC_OPCNT_EN` defined:
  - Adds output `op_count` (16 bits, reset 0).
  - Increments on each completed output handshake; wraps 0xFFFF→0.
- Undefined: the port and its counter are absent. All other behaviour is identical.

## Structure
- Package `systolic_pkg` holds:
  - the state enum;
  - lane count (5) and result count (9);
  - a function deriving RES_W from N;
  - tap index constants;
  - capture offset constants.
- Sub-module `sys_skew_gen`: given the latched A/B and a wavefront index 0..3, it produces the lane buses combinationally. Index 3 gives zeros. The controller registers its output.

## Test plan
- A = 1..9 row-major, B = identity, `out_ready` = 1 → `c_flat` = 1..9, `out_valid` high 7 edges after accept, one cycle wide.
- A all 31, B all 31 → every c element = 2883.
- `out_ready` = 0 for 10 cycles after `out_valid` rises → `c_flat` is stable and `in_ready` stays low. On release, IDLE is reached the next cycle.
- Inputs held valid from reset release → `in_ready` is low for 8 cycles, then the first accept occurs.
- `rst` pulsed at E0+4 → no `out_valid`; the lanes read zero the cycle after the reset edge.
- `in_valid` pulsed during FEED1 with different operands → ignored, and the result reflects the first operands only.

Source files
------------

// File: rtl/systolic_pkg.sv
// systolic_pkg: shared definitions for the 3x3 systolic array stream controller.
//   - state_e     : controller state encoding
//   - LANES/NRES  : array lane count and result element count
//   - res_width() : result element width derived from operand width
//   - TAP_*       : index of each array result tap on the res_tap bus
//   - CAP_OFS*    : capture group offsets, in edges after CAP_LAT
package systolic_pkg;

  localparam int unsigned LANES = 5;
  localparam int unsigned NRES  = 9;

  typedef enum logic [3:0] {
    ST_DRAIN,
    ST_IDLE,
    ST_FEED0,
    ST_FEED1,
    ST_FEED2,
    ST_WAIT,
    ST_CAP0,
    ST_CAP1,
    ST_CAP2,
    ST_HOLD
  } state_e;

  // Product of two N-bit values plus headroom for the three-term sum.
  function automatic int unsigned res_width(input int unsigned n);
    return 2 * n + 4;
  endfunction

  localparam int unsigned TAP_PE19 = 0;
  localparam int unsigned TAP_PE16 = 1;
  localparam int unsigned TAP_PE12 = 2;
  localparam int unsigned TAP_PE18 = 3;
  localparam int unsigned TAP_PE17 = 4;

  localparam int unsigned CAP_OFS0 = 0;
  localparam int unsigned CAP_OFS1 = 1;
  localparam int unsigned CAP_OFS2 = 2;

endpackage

// File: rtl/sys_skew_gen.sv
// sys_skew_gen: combinational wavefront generator for the 3x3 systolic array.
//   a_flat, b_flat : latched operands, row-major, element 11 at the LSBs
//   wave           : wavefront index 0..2; 3 yields all-zero lanes
//   lane_a, lane_b : LANES x N lane buses, lane 0 at the LSBs
// Wavefront w places row w of A on lanes w..w+2 and column w of B on lanes w..w+2.
module sys_skew_gen
  import systolic_pkg::*;
#(
  parameter int unsigned N = 5
) (
  input  logic [NRES*N-1:0]  a_flat,
  input  logic [NRES*N-1:0]  b_flat,
  input  logic [1:0]         wave,
  output logic [LANES*N-1:0] lane_a,
  output logic [LANES*N-1:0] lane_b
);

  always_comb begin
    int unsigned w;
    lane_a = '0;
    lane_b = '0;
    w      = 32'(wave);
    if (wave != 2'd3) begin
      for (int unsigned j = 0; j < 3; j++) begin
        lane_a[(w + j) * N +: N] = a_flat[(w * 3 + j) * N +: N];
        lane_b[(w + j) * N +: N] = b_flat[(j * 3 + w) * N +: N];
      end
    end
  end

endmodule

// File: rtl/systolic_stream_ctrl.sv
// systolic_stream_ctrl: host-side initiator for the 3x3 systolic multiplier array.
//   clk, rst         : single clock, synchronous active-high reset
//   in_valid/ready   : operand pair handshake (a_flat, b_flat, row-major)
//   lane_a, lane_b   : registered array lane buses (skewed wavefronts, then zeros)
//   res_tap          : array result taps 0..4 (PE19, PE16, PE12, PE18, PE17)
//   out_valid/ready  : result handshake; c_flat is the row-major 3x3 result
// Optional: define SYSTOLIC_OPCNT_EN to add the 16-bit op_count output.
// CAP_LAT must be at least 4.
module systolic_stream_ctrl
  import systolic_pkg::*;
#(
  parameter int unsigned N       = 5,
  parameter int unsigned RES_W   = res_width(N),
  parameter int unsigned CAP_LAT = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NRES*N-1:0]      a_flat,
  input  logic [NRES*N-1:0]      b_flat,
  output logic [LANES*N-1:0]     lane_a,
  output logic [LANES*N-1:0]     lane_b,
  input  logic [LANES*RES_W-1:0] res_tap,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NRES*RES_W-1:0]  c_flat
`ifdef SYSTOLIC_OPCNT_EN
  ,
  output logic [15:0]            op_count
`endif
);

  localparam int unsigned CNT_W = $clog2(CAP_LAT + 4);
  localparam logic [CNT_W-1:0] DRAIN_LEN = CNT_W'(CAP_LAT + 3);
  // Cycles spent in WAIT so that CAP0 is the state just before edge E0+CAP_LAT.
  localparam logic [CNT_W-1:0] WAIT_LEN  = CNT_W'((CAP_LAT > 4) ? CAP_LAT - 5 : 0);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NRES*N-1:0]     a_q, a_d;
  logic [NRES*N-1:0]     b_q, b_d;
  logic [NRES*RES_W-1:0] c_q, c_d;
  logic [LANES*N-1:0]    lane_a_q, lane_b_q;
  logic [LANES*N-1:0]    lane_a_d, lane_b_d;
  logic [NRES*N-1:0]     skew_a, skew_b;
  logic [1:0]            wave;

  // Wavefront 0 is registered on the accept edge, before the operands land in
  // a_q/b_q, so IDLE feeds the generator straight from the input ports.
  always_comb begin
    skew_a = a_q;
    skew_b = b_q;
    wave   = 2'd3;
    unique case (state_q)
      ST_IDLE: begin
        skew_a = a_flat;
        skew_b = b_flat;
        if (in_valid) wave = 2'd0;
      end
      ST_FEED0: wave = 2'd1;
      ST_FEED1: wave = 2'd2;
      default:  wave = 2'd3;
    endcase
  end

  sys_skew_gen #(
    .N (N)
  ) u_skew (
    .a_flat (skew_a),
    .b_flat (skew_b),
    .wave   (wave),
    .lane_a (lane_a_d),
    .lane_b (lane_b_d)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    unique case (state_q)
      ST_DRAIN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a_flat;
          b_d     = b_flat;
          state_d = ST_FEED0;
        end
      end
      ST_FEED0: state_d = ST_FEED1;
      ST_FEED1: state_d = ST_FEED2;
      ST_FEED2: begin
        if (CAP_LAT > 4) begin
          state_d = ST_WAIT;
          cnt_d   = WAIT_LEN;
        end else begin
          state_d = ST_CAP0;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_CAP0;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_CAP0: begin
        c_d[0*RES_W +: RES_W] = res_tap[TAP_PE19*RES_W +: RES_W];
        c_d[1*RES_W +: RES_W] = res_tap[TAP_PE16*RES_W +: RES_W];
        c_d[2*RES_W +: RES_W] = res_tap[TAP_PE12*RES_W +: RES_W];
        c_d[3*RES_W +: RES_W] = res_tap[TAP_PE18*RES_W +: RES_W];
        c_d[6*RES_W +: RES_W] = res_tap[TAP_PE17*RES_W +: RES_W];
        state_d = ST_CAP1;
      end
      ST_CAP1: begin
        c_d[4*RES_W +: RES_W] = res_tap[TAP_PE19*RES_W +: RES_W];
        c_d[5*RES_W +: RES_W] = res_tap[TAP_PE16*RES_W +: RES_W];
        c_d[7*RES_W +: RES_W] = res_tap[TAP_PE18*RES_W +: RES_W];
        state_d = ST_CAP2;
      end
      ST_CAP2: begin
        c_d[8*RES_W +: RES_W] = res_tap[TAP_PE19*RES_W +: RES_W];
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_DRAIN;
        cnt_d   = DRAIN_LEN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_DRAIN;
      cnt_q    <= DRAIN_LEN;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      lane_a_q <= '0;
      lane_b_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      lane_a_q <= lane_a_d;
      lane_b_q <= lane_b_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_HOLD);
  assign lane_a    = lane_a_q;
  assign lane_b    = lane_b_q;
  assign c_flat    = c_q;

`ifdef SYSTOLIC_OPCNT_EN
  logic [15:0] opcnt_q, opcnt_d;

  always_comb begin
    opcnt_d = opcnt_q;
    if (state_q == ST_HOLD && out_ready) opcnt_d = opcnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) opcnt_q <= '0;
    else     opcnt_q <= opcnt_d;
  end

  assign op_count = opcnt_q;
`endif

endmodule

// File: tb/tb_systolic_stream_ctrl.sv
// tb_systolic_stream_ctrl: self-checking bench for systolic_stream_ctrl.
// The bench plays the array: it computes C = A*B arithmetically and presents
// the products on the result taps only at the capture edges, with random
// values on every other tap/cycle.
module tb_systolic_stream_ctrl;
  import systolic_pkg::*;

  localparam int N     = 5;
  localparam int RES_W = 2 * N + 4;
  localparam int K     = 5;
  localparam int AW    = 9 * N;
  localparam int LW    = 5 * N;
  localparam int TW    = 5 * RES_W;
  localparam int CW    = 9 * RES_W;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] a_flat;
  logic [AW-1:0] b_flat;
  logic [LW-1:0] lane_a;
  logic [LW-1:0] lane_b;
  logic [TW-1:0] res_tap;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] c_flat;
`ifdef SYSTOLIC_OPCNT_EN
  logic [15:0]   op_count;
`endif

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  int unsigned n_done = 0;

  always #5 clk = ~clk;

  systolic_stream_ctrl #(
    .N       (N),
    .RES_W   (RES_W),
    .CAP_LAT (K)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_flat    (a_flat),
    .b_flat    (b_flat),
    .lane_a    (lane_a),
    .lane_b    (lane_b),
    .res_tap   (res_tap),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c_flat    (c_flat)
`ifdef SYSTOLIC_OPCNT_EN
    ,
    .op_count  (op_count)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] rnd_op();
    logic [AW-1:0] r;
    r = '0;
    for (int i = 0; i < 9; i++) r[i*N +: N] = N'($urandom_range(0, (1 << N) - 1));
    return r;
  endfunction

  // C[i][j] = sum_k A[i][k]*B[k][j], unsigned.
  function automatic logic [CW-1:0] model_c(input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [CW-1:0] r;
    int unsigned s;
    r = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        s = 0;
        for (int k = 0; k < 3; k++)
          s = s + 32'(a[(i*3+k)*N +: N]) * 32'(b[(k*3+j)*N +: N]);
        r[(i*3+j)*RES_W +: RES_W] = RES_W'(s);
      end
    return r;
  endfunction

  // Lane l of wavefront e carries A[e][l-e]; zero outside wavefronts 0..2.
  function automatic logic [LW-1:0] exp_lane_a(input logic [AW-1:0] m, input int e);
    logic [LW-1:0] r;
    r = '0;
    if (e >= 0 && e < 3)
      for (int l = 0; l < 5; l++) begin
        int c;
        c = l - e;
        if (c >= 0 && c < 3) r[l*N +: N] = m[(e*3+c)*N +: N];
      end
    return r;
  endfunction

  // Lane l of wavefront e carries B[l-e][e].
  function automatic logic [LW-1:0] exp_lane_b(input logic [AW-1:0] m, input int e);
    logic [LW-1:0] r;
    r = '0;
    if (e >= 0 && e < 3)
      for (int l = 0; l < 5; l++) begin
        int c;
        c = l - e;
        if (c >= 0 && c < 3) r[l*N +: N] = m[(c*3+e)*N +: N];
      end
    return r;
  endfunction

  // Tap bus for edge E0+e: products appear only where the array would deliver them.
  function automatic logic [TW-1:0] taps_for(input int e, input logic [CW-1:0] c);
    logic [TW-1:0] t;
    for (int i = 0; i < 5; i++) t[i*RES_W +: RES_W] = RES_W'($urandom_range(0, (1 << RES_W) - 1));
    if (e == K + int'(CAP_OFS0)) begin
      t[0*RES_W +: RES_W] = c[0*RES_W +: RES_W];
      t[1*RES_W +: RES_W] = c[1*RES_W +: RES_W];
      t[2*RES_W +: RES_W] = c[2*RES_W +: RES_W];
      t[3*RES_W +: RES_W] = c[3*RES_W +: RES_W];
      t[4*RES_W +: RES_W] = c[6*RES_W +: RES_W];
    end else if (e == K + int'(CAP_OFS1)) begin
      t[0*RES_W +: RES_W] = c[4*RES_W +: RES_W];
      t[1*RES_W +: RES_W] = c[5*RES_W +: RES_W];
      t[3*RES_W +: RES_W] = c[7*RES_W +: RES_W];
    end else if (e == K + int'(CAP_OFS2)) begin
      t[0*RES_W +: RES_W] = c[8*RES_W +: RES_W];
    end
    return t;
  endfunction

  // Entered just after the last reset edge; drain lasts K+3 cycles.
  task automatic drain_check();
    for (int i = 0; i < K + 3; i++) begin
      if (i > 0) begin
        res_tap = taps_for(-1, '0);
        tick();
      end
      chk("drain_in_ready", 128'(in_ready), 128'(0));
      chk("drain_out_valid", 128'(out_valid), 128'(0));
      chk("drain_lanes", 128'({lane_a, lane_b}), 128'(0));
    end
    res_tap = taps_for(-1, '0);
    tick();
    chk("drain_done_in_ready", 128'(in_ready), 128'(1));
  endtask

  // One operation from IDLE. hold: HOLD cycles with out_ready low.
  // poke: second operand pair offered during FEED1. rst_at: edge index for a reset (-1 none).
  task automatic run_op(input string tag, input logic [AW-1:0] opa, input logic [AW-1:0] opb,
                        input int hold, input bit poke, input int rst_at);
    logic [CW-1:0] expc;
    expc = model_c(opa, opb);
    chk({tag, "_idle_in_ready"}, 128'(in_ready), 128'(1));
    a_flat    = opa;
    b_flat    = opb;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    for (int e = 0; e <= K + 2; e++) begin
      res_tap = taps_for(e, expc);
      if (poke && e == 2) begin
        in_valid = 1'b1;
        a_flat   = rnd_op();
        b_flat   = rnd_op();
      end
      if (e == rst_at) rst = 1'b1;
      tick();
      in_valid = 1'b0;
      if (e == 0) begin
        a_flat = rnd_op();
        b_flat = rnd_op();
      end
      if (e == rst_at) begin
        rst = 1'b0;
        chk({tag, "_rst_lanes"}, 128'({lane_a, lane_b}), 128'(0));
        chk({tag, "_rst_out_valid"}, 128'(out_valid), 128'(0));
        chk({tag, "_rst_in_ready"}, 128'(in_ready), 128'(0));
        chk({tag, "_rst_c_flat"}, 128'(c_flat), 128'(0));
        return;
      end
      chk({tag, "_lane_a"}, 128'(lane_a), 128'(exp_lane_a(opa, e)));
      chk({tag, "_lane_b"}, 128'(lane_b), 128'(exp_lane_b(opb, e)));
      chk({tag, "_out_valid"}, 128'(out_valid), 128'(e == K + 2));
      chk({tag, "_busy_in_ready"}, 128'(in_ready), 128'(0));
    end
    chk({tag, "_c_flat"}, 128'(c_flat), 128'(expc));
    for (int h = 0; h < hold; h++) begin
      res_tap = taps_for(-1, '0);
      tick();
      chk({tag, "_hold_out_valid"}, 128'(out_valid), 128'(1));
      chk({tag, "_hold_c_flat"}, 128'(c_flat), 128'(expc));
      chk({tag, "_hold_in_ready"}, 128'(in_ready), 128'(0));
    end
    out_ready = 1'b1;
    res_tap   = taps_for(-1, '0);
    tick();
    n_done++;
    chk({tag, "_done_out_valid"}, 128'(out_valid), 128'(0));
    chk({tag, "_done_in_ready"}, 128'(in_ready), 128'(1));
  endtask

  initial begin
    logic [AW-1:0] seq_a, ident_b, all31;
    for (int i = 0; i < 9; i++) begin
      seq_a[i*N +: N] = N'(i + 1);
      all31[i*N +: N] = N'(31);
      ident_b[i*N +: N] = N'((i % 4) == 0);
    end

    // Reset with operands already offered; they must wait out the drain.
    rst       = 1'b1;
    in_valid  = 1'b1;
    a_flat    = seq_a;
    b_flat    = ident_b;
    out_ready = 1'b0;
    res_tap   = taps_for(-1, '0);
    tick();
    tick();
    chk("reset_lanes", 128'({lane_a, lane_b}), 128'(0));
    chk("reset_c_flat", 128'(c_flat), 128'(0));
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_in_ready", 128'(in_ready), 128'(0));
    rst = 1'b0;
    drain_check();

    run_op("ident", seq_a, ident_b, 0, 1'b0, -1);
    run_op("max31", all31, all31, 0, 1'b0, -1);
    run_op("backpressure", rnd_op(), rnd_op(), 10, 1'b0, -1);
    run_op("poke_feed1", rnd_op(), rnd_op(), 0, 1'b1, -1);

    run_op("mid_reset", rnd_op(), rnd_op(), 0, 1'b0, 4);
    drain_check();

    for (int i = 0; i < 6; i++)
      run_op("random", rnd_op(), rnd_op(), int'($urandom_range(0, 3)), 1'b0, -1);

`ifdef SYSTOLIC_OPCNT_EN
    chk("op_count", 128'(op_count), 128'(n_done));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
